// File: rtl/ram_dp_be.sv
// ram_dp_be: simple-dual-port RAM with byte enables, post-reset clear FSM and write-first read.
// Define RAM_DP_BE_OUT_REG_EN to add an output register stage (read latency 2).
module ram_dp_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  localparam int BE_WIDTH = DATA_WIDTH / 8,
  localparam int DEPTH = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);
  typedef enum logic {INIT, READY} state_e;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word, rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d, wr_go, rd_go, fwd;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_go = (state_q == READY) && wr_en;
    rd_go = (state_q == READY) && rd_en;
    fwd = wr_go && (wr_addr == rd_addr);
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      state_d = &cnt_q ? READY : INIT;
    end
    // Write-first: merge enabled bytes of the concurrent write into the read word
    rd_word = mem[rd_addr];
    for (int i = 0; i < BE_WIDTH; i++)
      if (fwd && wr_be[i]) rd_word[8*i+:8] = wr_data[8*i+:8];
    rd_valid_d = rd_go;
    rd_data_d = rd_go ? rd_word : rd_data_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  always_ff @(posedge clk)
    if (state_q == INIT) mem[cnt_q] <= '0;
    else if (wr_go)
      for (int i = 0; i < BE_WIDTH; i++)
        if (wr_be[i]) mem[wr_addr][8*i+:8] <= wr_data[8*i+:8];
  assign init_busy = (state_q == INIT);
`ifdef RAM_DP_BE_OUT_REG_EN
  logic [DATA_WIDTH-1:0] rd_data2_q;
  logic rd_valid2_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_data2_q <= '0;
      rd_valid2_q <= 1'b0;
    end else begin
      rd_data2_q <= rd_data_q;
      rd_valid2_q <= rd_valid_q;
    end
  assign rd_data = rd_data2_q;
  assign rd_valid = rd_valid2_q;
`else
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif
endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: directed self-checking bench for ram_dp_be (default 32-bit x 256 configuration).
module tb_ram_dp_be;
`ifdef RAM_DP_BE_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 256;
  logic clk = 1'b0, rst = 1'b1, init_busy, wr_en = 1'b0, rd_en = 1'b0, rd_valid;
  logic [7:0] wr_addr = '0, rd_addr = '0;
  logic [3:0] wr_be = '0;
  logic [31:0] wr_data = '0, rd_data;
  int vectors = 0, errs = 0;
  ram_dp_be dut (
    .clk(clk), .rst(rst), .init_busy(init_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_init(input string tag);
    int n = 0;
    logic seen = 1'b0;
    while (init_busy && n < DEPTH + 8) begin
      @(posedge clk); #1;
      n++;
      seen |= rd_valid;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk({tag, "_len"}, n, DEPTH);
    chk({tag, "_novalid"}, {31'b0, seen}, 0);
  endtask
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask
  task automatic do_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    chk({tag, "_valid"}, {31'b0, rd_valid}, 1);
    chk({tag, "_data"}, rd_data, exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'b0, rd_valid}, 0);
  endtask
  task automatic do_rw(input string tag, input logic [7:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic [7:0] ra, input logic [31:0] exp);
    wr_en = 1'b1; wr_addr = wa; wr_data = wd; wr_be = be;
    do_read(tag, ra, exp);
  endtask
  initial begin
    logic [7:0] ba [3];
    logic [31:0] be_exp [3];
    ba[0] = 8'd3; ba[1] = 8'd5; ba[2] = 8'd6;
    be_exp[0] = 32'hAA22BE44; be_exp[1] = 32'hCAFEF00D; be_exp[2] = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, init_busy}, 1);
    chk("rst_valid", {31'b0, rd_valid}, 0);
    chk("rst_data", rd_data, 0);
    // Requests held during INIT must be ignored
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 8'd2; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 8'd2;
    wait_init("init1");
    for (int a = 0; a < DEPTH; a++) do_read("clear", 8'(a), 32'h0);
    do_write(8'd3, 32'hDEADBEEF, 4'hF);
    do_read("full_wr", 8'd3, 32'hDEADBEEF);
    do_write(8'd3, 32'h11223344, 4'b0101);
    do_read("byte_wr", 8'd3, 32'hDE22BE44);
    do_write(8'd3, 32'h00000000, 4'b0000);
    do_read("be_zero", 8'd3, 32'hDE22BE44);
    do_rw("fwd_full", 8'd5, 32'hCAFEF00D, 4'hF, 8'd5, 32'hCAFEF00D);
    do_rw("diff_addr", 8'd6, 32'h12345678, 4'hF, 8'd7, 32'h0);
    do_read("rd6", 8'd6, 32'h12345678);
    do_rw("fwd_part", 8'd3, 32'hAA000000, 4'b1000, 8'd3, 32'hAA22BE44);
    // Back-to-back reads, one per cycle
    rd_en = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      if (i < 3) rd_addr = ba[i]; else rd_en = 1'b0;
      @(posedge clk); #1;
      if (i >= LAT - 1) begin
        chk("b2b_valid", {31'b0, rd_valid}, 1);
        chk("b2b_data", rd_data, be_exp[i-LAT+1]);
      end
    end
    rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_data", rd_data, 32'h12345678);
    chk("hold_valid", {31'b0, rd_valid}, 0);
    do_write(8'd255, 32'h55AA55AA, 4'hF);
    do_read("top_addr", 8'd255, 32'h55AA55AA);
    // Reset right after a read request, then again mid-INIT
    rd_en = 1'b1; rd_addr = 8'd255;
    @(posedge clk); #1;
    rd_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst2_valid", {31'b0, rd_valid}, 0);
    chk("rst2_data", rd_data, 0);
    chk("rst2_busy", {31'b0, init_busy}, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (DEPTH / 2) @(posedge clk);
    #1;
    chk("half_busy", {31'b0, init_busy}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init("init2");
    do_read("top_clear", 8'd255, 32'h0);
    do_read("a3_clear", 8'd3, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/ram_dp_be.md
# ram_dp_be

Parametrised simple-dual-port synchronous RAM with one write port, one read port and per-byte write enables. A built-in state machine clears the whole array to zero after reset, so reads never return uninitialised contents. The read port has a valid flag. It is the next-generation replacement for the single-port `ram_simple` storage block and is used wherever a datapath needs concurrent write and read access to a buffer.

## Interface
- `DATA_WIDTH`, default 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, default 8: address width; depth is `DEPTH = 2**ADDR_WIDTH` words.
- `BE_WIDTH`, derived, equals `DATA_WIDTH/8`: number of byte enables.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `init_busy`, out, 1: high while the clear sequence runs; both ports are ignored while it is high.
- `wr_en`, in, 1: write request.
- `wr_addr`, in, `ADDR_WIDTH`: write address.
- `wr_be`, in, `BE_WIDTH`: byte enables; bit i selects `wr_data[8i+7:8i]`.
- `wr_data`, in, `DATA_WIDTH`: write data.
- `rd_en`, in, 1: read request.
- `rd_addr`, in, `ADDR_WIDTH`: read address.
- `rd_data`, out, `DATA_WIDTH`: read data; holds its last value when no read completes.
- `rd_valid`, out, 1: one-cycle pulse marking `rd_data` as the result of a read.

## Operation
- The FSM has two states, `INIT` and `READY`. `rst` forces `INIT` and clears the clear-address counter to 0.
- **INIT state**
  - Each rising edge writes zero to the word at the counter and increments the counter.
  - On the edge that clears word `DEPTH-1`, the FSM moves to `READY`.
  - `wr_en` and `rd_en` are ignored. No `rd_valid` pulse is produced.
- **READY state, writes**
  - If `wr_en` is high, the edge writes byte i of `wr_data` to `wr_addr` only for bytes whose `wr_be[i]` is high. Other bytes keep their contents.
  - `wr_en` with `wr_be` all zero changes nothing.
- **READY state, reads**
  - If `rd_en` is high, the edge captures the word at `rd_addr` and asserts `rd_valid` for the following cycle.
  - Back-to-back reads are allowed, one per cycle at full throughput.
- **Read during write to the same address (write-first)**
  - `rd_data` returns the merged word: `wr_data` bytes where `wr_be` is set, old contents elsewhere.
- **Read and write to different addresses in the same cycle**: fully independent.
- **Reset mid-operation**
  - Any `rst` assertion, including during `INIT`, restarts the clear sequence from address 0.
  - Any in-flight `rd_valid` is dropped.
- **Address range**: addresses are exactly `ADDR_WIDTH` bits wide, so there is no out-of-range case. Address `DEPTH-1` is a normal word.

## Timing
- Reset values: `init_busy` = 1, `rd_valid` = 0, `rd_data` = 0, FSM = `INIT`, counter = 0.
- `init_busy` stays high for exactly `DEPTH` rising edges after `rst` is released. It falls after edge number `DEPTH`.
- The first request accepted is the one presented on edge `DEPTH+1`.
- Read latency is 1 cycle: request on edge N, `rd_data` and `rd_valid` are valid from edge N until edge N+1.
- Write latency is 0 cycles: a read issued on the edge after a write returns the written data.
- `rd_data` holds its value between reads. `rd_valid` is high only in cycles that follow an accepted read.

## Configuration
- Macro `RAM_DP_BE_OUT_REG_EN` selects an extra output register on the read path.
- **Defined**
  - `rd_data` and `rd_valid` pass through an extra register stage, giving read latency 2.
  - Write-first forwarding still applies on the request edge.
  - Reset clears both stages.
- **Undefined**: read latency is 1, as specified above.
- All other behaviour is identical in both builds.

## Test plan
- Release `rst`, wait for `init_busy` to fall, then read every address: all words 0, `init_busy` low exactly `DEPTH` cycles after release.
- Write 0xDEADBEEF to address 3 with `wr_be` = 4'hF, then read address 3: `rd_data` = 0xDEADBEEF with a one-cycle `rd_valid` (two cycles with `RAM_DP_BE_OUT_REG_EN`).
- Write 0x11223344 to address 3 with `wr_be` = 4'b0101, then read address 3: `rd_data` = 0xDE22BE44.
- In the same cycle, write 0xCAFEF00D to address 5 and read address 5, where address 5 held 0: `rd_data` = 0xCAFEF00D. Also write address 6 while reading address 7: `rd_data` = old contents of address 7.
- Assert `rst` while `INIT` is half done, after writing address `DEPTH-1` before the reset: clear sequence restarts, `rd_valid` = 0, and a later read of address `DEPTH-1` returns 0.
- During `INIT`, assert `wr_en` to address 2 with 0xFFFFFFFF and `rd_en`: no `rd_valid`, and after `INIT` address 2 reads 0.
